// File: rtl/clk_div_gen.sv
// clk_div_gen: NCH independent 50%-duty clock dividers, period 2*(D+1) clk cycles.
// Optional saturating rising-edge counters are built when CLK_DIV_GEN_EDGE_CNT_EN is defined.
module clk_div_gen #(
    parameter int NCH   = 4,
    parameter int DIV_W = 8,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       en,
    input  logic [NCH*DIV_W-1:0] div,
    input  logic [NCH-1:0]       load,
`ifdef CLK_DIV_GEN_EDGE_CNT_EN
    input  logic [NCH-1:0]       cnt_clr,
    output logic [NCH*CNT_W-1:0] edge_cnt,
`endif
    output logic [NCH-1:0]       clk_out,
    output logic [NCH-1:0]       clk_out_n,
    output logic [NCH-1:0]       rise
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    if (NCH < 1 || NCH > 16 || DIV_W < 1 || CNT_W < 1) begin : g_param_check
        $error("clk_div_gen: parameter out of range");
    end

`ifdef CLK_DIV_GEN_EDGE_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction
`endif

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nxt;
        logic [DIV_W-1:0] r_hc;
        logic [DIV_W-1:0] w_hc_nxt;
        logic [DIV_W-1:0] r_shadow;
        logic [DIV_W-1:0] w_shadow_nxt;
        logic [DIV_W-1:0] r_active;
        logic [DIV_W-1:0] w_active_nxt;
        logic [DIV_W-1:0] w_div;
        logic             w_terminal;
        logic             r_clk_out;
        logic             r_clk_out_n;
        logic             r_rise;

        assign w_div      = div[k*DIV_W +: DIV_W];
        assign w_terminal = (r_hc == r_active);

        // The active divisor only changes on a LOW->HIGH boundary or while idle,
        // so a load landing on that boundary already governs the new HIGH phase.
        always_comb begin
            w_state_nxt  = r_state;
            w_hc_nxt     = r_hc;
            w_shadow_nxt = load[k] ? w_div : r_shadow;
            w_active_nxt = r_active;
            unique case (r_state)
                ST_IDLE: begin
                    w_hc_nxt     = '0;
                    w_active_nxt = w_shadow_nxt;
                    if (en[k]) begin
                        w_state_nxt = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (!en[k]) begin
                        w_state_nxt = ST_IDLE;
                        w_hc_nxt    = '0;
                    end else if (w_terminal) begin
                        w_state_nxt  = ST_HIGH;
                        w_hc_nxt     = '0;
                        w_active_nxt = w_shadow_nxt;
                    end else begin
                        w_hc_nxt = r_hc + DIV_W'(1);
                    end
                end
                ST_HIGH: begin
                    // A high phase always runs to completion before stopping.
                    if (w_terminal) begin
                        w_state_nxt = en[k] ? ST_LOW : ST_IDLE;
                        w_hc_nxt    = '0;
                    end else begin
                        w_hc_nxt = r_hc + DIV_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_hc_nxt    = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state     <= ST_IDLE;
                r_hc        <= '0;
                r_shadow    <= '0;
                r_active    <= '0;
                r_clk_out   <= 1'b0;
                r_clk_out_n <= 1'b0;
                r_rise      <= 1'b0;
            end else begin
                r_state     <= w_state_nxt;
                r_hc        <= w_hc_nxt;
                r_shadow    <= w_shadow_nxt;
                r_active    <= w_active_nxt;
                r_clk_out   <= (w_state_nxt == ST_HIGH);
                r_clk_out_n <= (w_state_nxt == ST_LOW);
                r_rise      <= (r_state == ST_LOW) && (w_state_nxt == ST_HIGH);
            end
        end

        assign clk_out[k]   = r_clk_out;
        assign clk_out_n[k] = r_clk_out_n;
        assign rise[k]      = r_rise;

`ifdef CLK_DIV_GEN_EDGE_CNT_EN
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (cnt_clr[k]) begin
                r_cnt <= '0;
            end else if (r_rise) begin
                r_cnt <= sat_inc(r_cnt);
            end
        end

        assign edge_cnt[k*CNT_W +: CNT_W] = r_cnt;
`endif
    end

endmodule
